// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: memory-op encodings, FSM states,
// datapath widths and the MEM/WB pipeline register payload.
package mem_wb_stage_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned XLEN            = 32;
  localparam int unsigned RA_W            = 5;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_STORE = 2'b01,
    MEM_LOAD  = 2'b10,
    MEM_RSVD  = 2'b11
  } mem_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic            reg_write;
    logic [RA_W-1:0] rd_addr;
    logic [XLEN-1:0] wb_data;
  } mem_wb_t;

  // The reserved encoding 2'b11 behaves like a non-memory instruction.
  function automatic logic is_access(input logic [1:0] op);
    return (op == MEM_LOAD) || (op == MEM_STORE);
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM/WB stage (master)
// and the data memory (slave).
interface mem_wb_stage_if;
  import mem_wb_stage_pkg::*;

  logic            dmem_req_o;
  logic            dmem_we_o;
  logic [XLEN-1:0] dmem_addr_o;
  logic [XLEN-1:0] dmem_wdata_o;
  logic            dmem_ack_i;
  logic [XLEN-1:0] dmem_rdata_i;

  modport master (
    output dmem_req_o,
    output dmem_we_o,
    output dmem_addr_o,
    output dmem_wdata_o,
    input  dmem_ack_i,
    input  dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o,
    input  dmem_we_o,
    input  dmem_addr_o,
    input  dmem_wdata_o,
    output dmem_ack_i,
    output dmem_rdata_i
  );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the write enable and leaves the
// destination register and data untouched.
module mem_wb_reg
  import mem_wb_stage_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_bubble,
  input  mem_wb_t i_data,
  output mem_wb_t o_data
);

  mem_wb_t r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_bubble) begin
      r_data.reg_write <= 1'b0;
    end else begin
      r_data <= i_data;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: issues one data-memory access at a time, stalls upstream
// while it is outstanding, aborts on timeout or misalignment, and feeds writeback.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            WB_i,
  input  logic [1:0]      Mem_i,
  input  logic [XLEN-1:0] Memaddr_i,
  input  logic [XLEN-1:0] Memdata_i,
  input  logic [XLEN-1:0] ALUres_i,
  input  logic [RA_W-1:0] rd_addr_i,
  mem_wb_stage_if.master  dmem,
  output logic            stall_o,
  output logic            RegWrite_o,
  output logic [RA_W-1:0] rd_addr_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            err_o
);

  localparam int unsigned      CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  logic    w_access;
  logic    w_aligned;
  logic    w_accept;
  logic    w_misalign;
  logic    w_ack;
  logic    w_timeout;
  logic    w_stall;
  logic    w_load_done;
  mem_wb_t w_wb_in;
  mem_wb_t w_wb_out;

  assign w_access  = is_access(Mem_i);
  assign w_aligned = (Memaddr_i[1:0] == 2'b00);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_misalign  = 1'b0;
    w_ack       = 1'b0;
    w_timeout   = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          if (w_aligned) begin
            w_accept    = 1'b1;
            w_stall     = 1'b1;
            w_state_nxt = ST_BUSY;
          end else begin
            w_misalign  = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (dmem.dmem_ack_i) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_count == TO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_stall     = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and updates together.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request outputs are registered, so dmem_ack_i never reaches dmem_req_o combinationally.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dmem.dmem_req_o   <= 1'b0;
      dmem.dmem_we_o    <= 1'b0;
      dmem.dmem_addr_o  <= '0;
      dmem.dmem_wdata_o <= '0;
      r_count           <= '0;
      r_err             <= 1'b0;
    end else begin
      dmem.dmem_req_o <= (w_state_nxt == ST_BUSY);
      r_err           <= w_misalign | w_timeout;
      if (w_accept) begin
        dmem.dmem_we_o    <= (Mem_i == MEM_STORE);
        dmem.dmem_addr_o  <= {2'b00, Memaddr_i[XLEN-1:2]};
        dmem.dmem_wdata_o <= Memdata_i;
        r_count           <= '0;
      end else if ((r_state == ST_BUSY) && !dmem.dmem_ack_i) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign w_load_done       = w_ack && !dmem.dmem_we_o;
  assign w_wb_in.reg_write = WB_i && !(w_misalign || w_timeout);
  assign w_wb_in.rd_addr   = rd_addr_i;
  assign w_wb_in.wb_data   = w_load_done ? dmem.dmem_rdata_i : ALUres_i;

  mem_wb_reg u_mem_wb_reg (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .i_bubble (w_stall),
    .i_data   (w_wb_in),
    .o_data   (w_wb_out)
  );

  assign stall_o    = w_stall;
  assign RegWrite_o = w_wb_out.reg_write;
  assign rd_addr_o  = w_wb_out.rd_addr;
  assign wb_data_o  = w_wb_out.wb_data;
  assign err_o      = r_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: the bench plays both the upstream pipeline
// and the data memory, with hand-computed expectations.
module tb_mem_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        WB_i;
  logic [1:0]  Mem_i;
  logic [31:0] Memaddr_i;
  logic [31:0] Memdata_i;
  logic [31:0] ALUres_i;
  logic [4:0]  rd_addr_i;
  logic        stall_o;
  logic        RegWrite_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] wb_data_o;
  logic        err_o;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_wb_stage_if dmem_bus ();

  mem_wb_stage #(.TIMEOUT(4)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .WB_i       (WB_i),
    .Mem_i      (Mem_i),
    .Memaddr_i  (Memaddr_i),
    .Memdata_i  (Memdata_i),
    .ALUres_i   (ALUres_i),
    .rd_addr_i  (rd_addr_i),
    .dmem       (dmem_bus),
    .stall_o    (stall_o),
    .RegWrite_o (RegWrite_o),
    .rd_addr_o  (rd_addr_o),
    .wb_data_o  (wb_data_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic wb, input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] alu, input logic [4:0] rd);
    WB_i      = wb;
    Mem_i     = op;
    Memaddr_i = addr;
    Memdata_i = wdata;
    ALUres_i  = alu;
    rd_addr_i = rd;
  endtask

  task automatic mem_rsp(input logic ack, input logic [31:0] rdata);
    dmem_bus.dmem_ack_i   = ack;
    dmem_bus.dmem_rdata_i = rdata;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    mem_rsp(1'b0, 32'h0);
    #12;
    tests_run++;
    if ({dmem_bus.dmem_req_o, dmem_bus.dmem_we_o, dmem_bus.dmem_addr_o, dmem_bus.dmem_wdata_o,
         RegWrite_o, rd_addr_o, wb_data_o, err_o} !== 105'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got nonzero registered outputs (req=%b rw=%b rd=%0d wb=%h err=%b) expected all 0",
               dmem_bus.dmem_req_o, RegWrite_o, rd_addr_o, wb_data_o, err_o);
    end
    tests_run++;
    if (stall_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_stall: got %b expected 0", stall_o);
    end
    rst_i = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    drive(1'b1, 2'b00, 32'h0, 32'h0, 32'd7, 5'd3);
    #1;
    tests_run++;
    if (stall_o !== 1'b0) begin
      tests_failed++; $display("FAIL alu_stall: got %b expected 0", stall_o);
    end
    tick();
    tests_run++;
    if ({RegWrite_o, rd_addr_o, wb_data_o} !== {1'b1, 5'd3, 32'd7}) begin
      tests_failed++;
      $display("FAIL alu_retire: got rw=%b rd=%0d wb=%h expected rw=1 rd=3 wb=00000007", RegWrite_o, rd_addr_o, wb_data_o);
    end
    // Reserved op 2'b11 must pass through like a non-memory instruction.
    drive(1'b1, 2'b11, 32'h0000_0102, 32'h0, 32'd9, 5'd4);
    #1;
    tests_run++;
    if (stall_o !== 1'b0) begin
      tests_failed++; $display("FAIL op11_stall: got %b expected 0", stall_o);
    end
    tick();
    tests_run++;
    if ({dmem_bus.dmem_req_o, err_o, RegWrite_o, rd_addr_o, wb_data_o} !== {1'b0, 1'b0, 1'b1, 5'd4, 32'd9}) begin
      tests_failed++;
      $display("FAIL op11_retire: got req=%b err=%b rw=%b rd=%0d wb=%h expected req=0 err=0 rw=1 rd=4 wb=00000009",
               dmem_bus.dmem_req_o, err_o, RegWrite_o, rd_addr_o, wb_data_o);
    end
  endtask

  task automatic test_load();
    int stall_cnt;
    drive(1'b1, 2'b00, 32'h0, 32'h0, 32'h00C0_FFEE, 5'd12);
    tick();
    stall_cnt = 0;
    drive(1'b1, 2'b10, 32'h0000_0100, 32'h0, 32'hAAAA_AAAA, 5'd5);
    mem_rsp(1'b0, 32'h0);
    #1;
    if (stall_o) stall_cnt++;
    tick();
    tests_run++;
    if ({dmem_bus.dmem_req_o, dmem_bus.dmem_we_o, dmem_bus.dmem_addr_o} !== {1'b1, 1'b0, 32'h0000_0040}) begin
      tests_failed++;
      $display("FAIL load_req: got req=%b we=%b addr=%h expected req=1 we=0 addr=00000040",
               dmem_bus.dmem_req_o, dmem_bus.dmem_we_o, dmem_bus.dmem_addr_o);
    end
    tests_run++;
    if ({RegWrite_o, rd_addr_o, wb_data_o} !== {1'b0, 5'd12, 32'h00C0_FFEE}) begin
      tests_failed++;
      $display("FAIL load_bubble: got rw=%b rd=%0d wb=%h expected rw=0 rd=12 wb=00c0ffee", RegWrite_o, rd_addr_o, wb_data_o);
    end
    if (stall_o) stall_cnt++;
    tick();
    if (stall_o) stall_cnt++;
    tick();
    mem_rsp(1'b1, 32'hDEAD_BEEF);
    #1;
    tests_run++;
    if ({dmem_bus.dmem_req_o, dmem_bus.dmem_addr_o} !== {1'b1, 32'h0000_0040}) begin
      tests_failed++;
      $display("FAIL load_addr_stable: got req=%b addr=%h expected req=1 addr=00000040", dmem_bus.dmem_req_o, dmem_bus.dmem_addr_o);
    end
    if (stall_o) stall_cnt++;
    tests_run++;
    if (stall_cnt !== 3) begin
      tests_failed++; $display("FAIL load_stall_cycles: got %0d expected 3", stall_cnt);
    end
    tick();
    mem_rsp(1'b0, 32'h0);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    tests_run++;
    if ({dmem_bus.dmem_req_o, err_o, RegWrite_o, rd_addr_o, wb_data_o} !== {1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      tests_failed++;
      $display("FAIL load_retire: got req=%b err=%b rw=%b rd=%0d wb=%h expected req=0 err=0 rw=1 rd=5 wb=deadbeef",
               dmem_bus.dmem_req_o, err_o, RegWrite_o, rd_addr_o, wb_data_o);
    end
  endtask

  task automatic test_store();
    drive(1'b0, 2'b01, 32'h0000_0040, 32'h1234_5678, 32'h0, 5'd7);
    #1;
    tests_run++;
    if (stall_o !== 1'b1) begin
      tests_failed++; $display("FAIL store_accept_stall: got %b expected 1", stall_o);
    end
    tick();
    mem_rsp(1'b1, 32'h0);
    #1;
    tests_run++;
    if ({dmem_bus.dmem_req_o, dmem_bus.dmem_we_o, dmem_bus.dmem_addr_o, dmem_bus.dmem_wdata_o, stall_o}
        !== {1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0}) begin
      tests_failed++;
      $display("FAIL store_req: got req=%b we=%b addr=%h wdata=%h stall=%b expected req=1 we=1 addr=00000010 wdata=12345678 stall=0",
               dmem_bus.dmem_req_o, dmem_bus.dmem_we_o, dmem_bus.dmem_addr_o, dmem_bus.dmem_wdata_o, stall_o);
    end
    tick();
    // Stray ack while idle alongside an ALU op: data must come from ALUres_i.
    drive(1'b1, 2'b00, 32'h0, 32'h0, 32'h77, 5'd8);
    mem_rsp(1'b1, 32'h0000_0BAD);
    tests_run++;
    if ({dmem_bus.dmem_req_o, RegWrite_o, err_o} !== 3'b000) begin
      tests_failed++;
      $display("FAIL store_retire: got req=%b rw=%b err=%b expected req=0 rw=0 err=0", dmem_bus.dmem_req_o, RegWrite_o, err_o);
    end
    tick();
    mem_rsp(1'b0, 32'h0);
    tests_run++;
    if ({dmem_bus.dmem_req_o, RegWrite_o, rd_addr_o, wb_data_o} !== {1'b0, 1'b1, 5'd8, 32'h77}) begin
      tests_failed++;
      $display("FAIL idle_ack_ignored: got req=%b rw=%b rd=%0d wb=%h expected req=0 rw=1 rd=8 wb=00000077",
               dmem_bus.dmem_req_o, RegWrite_o, rd_addr_o, wb_data_o);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b10, 32'h0000_0200, 32'h0, 32'h0, 5'd1);
    tick();
    mem_rsp(1'b1, 32'h1111_1111);
    tick();
    mem_rsp(1'b0, 32'h0);
    drive(1'b1, 2'b10, 32'h0000_0204, 32'h0, 32'h0, 5'd2);
    #1;
    tests_run++;
    if ({dmem_bus.dmem_req_o, stall_o, RegWrite_o, rd_addr_o, wb_data_o} !== {1'b0, 1'b1, 1'b1, 5'd1, 32'h1111_1111}) begin
      tests_failed++;
      $display("FAIL b2b_first: got req=%b stall=%b rw=%b rd=%0d wb=%h expected req=0 stall=1 rw=1 rd=1 wb=11111111",
               dmem_bus.dmem_req_o, stall_o, RegWrite_o, rd_addr_o, wb_data_o);
    end
    tick();
    tests_run++;
    if ({dmem_bus.dmem_req_o, dmem_bus.dmem_addr_o} !== {1'b1, 32'h0000_0081}) begin
      tests_failed++;
      $display("FAIL b2b_second_req: got req=%b addr=%h expected req=1 addr=00000081", dmem_bus.dmem_req_o, dmem_bus.dmem_addr_o);
    end
    mem_rsp(1'b1, 32'h2222_2222);
    tick();
    mem_rsp(1'b0, 32'h0);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    tests_run++;
    if ({dmem_bus.dmem_req_o, RegWrite_o, rd_addr_o, wb_data_o} !== {1'b0, 1'b1, 5'd2, 32'h2222_2222}) begin
      tests_failed++;
      $display("FAIL b2b_second: got req=%b rw=%b rd=%0d wb=%h expected req=0 rw=1 rd=2 wb=22222222",
               dmem_bus.dmem_req_o, RegWrite_o, rd_addr_o, wb_data_o);
    end
  endtask

  task automatic test_misaligned();
    drive(1'b1, 2'b10, 32'h0000_0102, 32'h0, 32'h55, 5'd6);
    #1;
    tests_run++;
    if (stall_o !== 1'b0) begin
      tests_failed++; $display("FAIL misalign_stall: got %b expected 0", stall_o);
    end
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    tests_run++;
    if ({dmem_bus.dmem_req_o, err_o, RegWrite_o, rd_addr_o} !== {1'b0, 1'b1, 1'b0, 5'd6}) begin
      tests_failed++;
      $display("FAIL misalign_err: got req=%b err=%b rw=%b rd=%0d expected req=0 err=1 rw=0 rd=6",
               dmem_bus.dmem_req_o, err_o, RegWrite_o, rd_addr_o);
    end
    tick();
    tests_run++;
    if ({dmem_bus.dmem_req_o, err_o} !== 2'b00) begin
      tests_failed++; $display("FAIL misalign_pulse_end: got req=%b err=%b expected req=0 err=0", dmem_bus.dmem_req_o, err_o);
    end
  endtask

  task automatic test_timeout();
    int req_cycles;
    int cyc;
    req_cycles = 0;
    cyc        = 0;
    drive(1'b1, 2'b10, 32'h0000_0300, 32'h0, 32'h0, 5'd9);
    mem_rsp(1'b0, 32'h0);
    #1;
    while (stall_o === 1'b1 && cyc < 20) begin
      tick();
      cyc++;
      if (dmem_bus.dmem_req_o === 1'b1) req_cycles++;
    end
    tests_run++;
    if (cyc >= 20) begin
      tests_failed++; $display("FAIL timeout_release: stall still %b after %0d cycles expected 0", stall_o, cyc);
    end
    tests_run++;
    if (req_cycles !== 4) begin
      tests_failed++; $display("FAIL timeout_req_cycles: got %0d expected 4", req_cycles);
    end
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    tests_run++;
    if ({dmem_bus.dmem_req_o, err_o, RegWrite_o, rd_addr_o} !== {1'b0, 1'b1, 1'b0, 5'd9}) begin
      tests_failed++;
      $display("FAIL timeout_abort: got req=%b err=%b rw=%b rd=%0d expected req=0 err=1 rw=0 rd=9",
               dmem_bus.dmem_req_o, err_o, RegWrite_o, rd_addr_o);
    end
    tick();
    tests_run++;
    if ({err_o, stall_o} !== 2'b00) begin
      tests_failed++; $display("FAIL timeout_pulse_end: got err=%b stall=%b expected err=0 stall=0", err_o, stall_o);
    end
  endtask

  task automatic test_reset_mid_busy();
    drive(1'b1, 2'b10, 32'h0000_0400, 32'h0, 32'h0, 5'd10);
    tick();
    tests_run++;
    if (dmem_bus.dmem_req_o !== 1'b1) begin
      tests_failed++; $display("FAIL rst_busy_req: got %b expected 1", dmem_bus.dmem_req_o);
    end
    #2;
    rst_i = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    #1;
    tests_run++;
    if ({dmem_bus.dmem_req_o, dmem_bus.dmem_we_o, dmem_bus.dmem_addr_o, dmem_bus.dmem_wdata_o,
         RegWrite_o, rd_addr_o, wb_data_o, err_o, stall_o} !== 106'd0) begin
      tests_failed++;
      $display("FAIL rst_busy_outputs: got req=%b addr=%h rw=%b rd=%0d wb=%h err=%b stall=%b expected all 0",
               dmem_bus.dmem_req_o, dmem_bus.dmem_addr_o, RegWrite_o, rd_addr_o, wb_data_o, err_o, stall_o);
    end
    #2;
    rst_i = 1'b1;
    mem_rsp(1'b1, 32'hFFFF_FFFF);
    tick();
    mem_rsp(1'b0, 32'h0);
    tests_run++;
    if ({dmem_bus.dmem_req_o, RegWrite_o, wb_data_o} !== {1'b0, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL rst_busy_abandon: got req=%b rw=%b wb=%h expected req=0 rw=0 wb=00000000",
               dmem_bus.dmem_req_o, RegWrite_o, wb_data_o);
    end
    drive(1'b1, 2'b00, 32'h0, 32'h0, 32'h0000_0ABC, 5'd11);
    tick();
    tests_run++;
    if ({RegWrite_o, rd_addr_o, wb_data_o} !== {1'b1, 5'd11, 32'h0000_0ABC}) begin
      tests_failed++;
      $display("FAIL rst_recover: got rw=%b rd=%0d wb=%h expected rw=1 rd=11 wb=00000abc", RegWrite_o, rd_addr_o, wb_data_o);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_misaligned();
    test_timeout();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
